// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: ALU op encodings, multiplier FSM
// states, EX pipeline register layout and the single-cycle ALU function.
package ex_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RA_W      = 5;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned SH_W      = 5;
  localparam int unsigned MUL_STEPS = 32;
  localparam int unsigned CNT_W     = $clog2(MUL_STEPS);

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_MUL  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic            valid;
    logic            reg_we;
    logic            dmem_we;
    logic            s_byte;
    logic            s_wrd;
    logic [RA_W-1:0] wra;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic            simm;
    alu_op_e         op;
  } ex_reg_t;

  // Single-cycle ALU result; MUL and the unused codes return 0 here.
  function automatic logic [XLEN-1:0] alu_calc(alu_op_e op, logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = XLEN'($signed(a) < $signed(b));
      OP_SLTU: r = XLEN'(a < b);
      OP_SLL:  r = a << b[SH_W-1:0];
      OP_SRL:  r = a >> b[SH_W-1:0];
      OP_SRA:  r = XLEN'($signed(a) >>> b[SH_W-1:0]);
      OP_LUI:  r = b << 16;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial-product step per cycle,
// returning the low word of a*b. Compiled only when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module mul_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] prod_q, prod_d;

  // State and datapath registers; reset abandons any partial product.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Next state: load operands on start, one shift-add per BUSY cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          prod_d   = '0;
        end
      end
      ST_BUSY: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// EX pipeline stage: EX register, single-cycle ALU and, with EX_MUL_EN
// defined, a 33-cycle-stall iterative MUL. Without EX_MUL_EN, op 12
// yields 0 and the stage never stalls.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_EX_valid,
  input  logic        i_EX_regWe,
  input  logic        i_EX_dMemWe,
  input  logic        i_EX_sByte,
  input  logic        i_EX_sWRD,
  input  logic [4:0]  i_EX_WRA,
  input  logic [31:0] i_EX_rd1,
  input  logic [31:0] i_EX_rd2,
  input  logic [31:0] i_EX_imm,
  input  logic        i_EX_sImm,
  input  logic [3:0]  i_EX_aluOp,
  output logic        o_EX_stall,
  output logic        o_EX_regWe,
  output logic        o_EX_dMemWe,
  output logic        o_EX_sByte,
  output logic        o_EX_sWRD,
  output logic [4:0]  o_EX_WRA,
  output logic [31:0] o_EX_aluOut,
  output logic [31:0] o_EX_rd2
);

  ex_reg_t         ex_q, ex_d;
  logic            stall;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_out;

  // Next EX register contents; a bubble drops both write enables.
  always_comb begin
    ex_d         = '0;
    ex_d.valid   = i_EX_valid;
    ex_d.reg_we  = i_EX_valid & i_EX_regWe;
    ex_d.dmem_we = i_EX_valid & i_EX_dMemWe;
    ex_d.s_byte  = i_EX_sByte;
    ex_d.s_wrd   = i_EX_sWRD;
    ex_d.wra     = i_EX_WRA;
    ex_d.rd1     = i_EX_rd1;
    ex_d.rd2     = i_EX_rd2;
    ex_d.imm     = i_EX_imm;
    ex_d.simm    = i_EX_sImm;
    ex_d.op      = alu_op_e'(i_EX_aluOp);
  end

  // EX register: capture when not stalled, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rstn)       ex_q <= '0;
    else if (!stall) ex_q <= ex_d;
  end

  assign opb = ex_q.simm ? ex_q.imm : ex_q.rd2;

`ifdef EX_MUL_EN
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  // A registered valid MUL starts the multiplier only from its idle state.
  assign mul_start = ex_q.valid && (ex_q.op == OP_MUL) && !mul_busy && !mul_done;
  assign stall     = mul_start | mul_busy;

  mul_iter u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .start   (mul_start),
    .a       (ex_q.rd1),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Result select: MUL reads the multiplier, everything else the ALU.
  always_comb begin
    alu_out = alu_calc(ex_q.op, ex_q.rd1, opb);
    if (ex_q.op == OP_MUL) alu_out = mul_prod;
  end
`else
  assign stall = 1'b0;

  // Result select: single-cycle ALU only.
  always_comb begin
    alu_out = alu_calc(ex_q.op, ex_q.rd1, opb);
  end
`endif

  // MEM-facing outputs; write enables are masked while stalled.
  assign o_EX_stall  = stall;
  assign o_EX_regWe  = ex_q.valid & ex_q.reg_we & ~stall;
  assign o_EX_dMemWe = ex_q.valid & ex_q.dmem_we & ~stall;
  assign o_EX_sByte  = ex_q.s_byte;
  assign o_EX_sWRD   = ex_q.s_wrd;
  assign o_EX_WRA    = ex_q.wra;
  assign o_EX_aluOut = alu_out;
  assign o_EX_rd2    = ex_q.rd2;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage against a behavioural model.
// Works with or without EX_MUL_EN defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_EX_valid, i_EX_regWe, i_EX_dMemWe, i_EX_sByte, i_EX_sWRD;
  logic [4:0]  i_EX_WRA;
  logic [31:0] i_EX_rd1, i_EX_rd2, i_EX_imm;
  logic        i_EX_sImm;
  logic [3:0]  i_EX_aluOp;
  logic        o_EX_stall, o_EX_regWe, o_EX_dMemWe, o_EX_sByte, o_EX_sWRD;
  logic [4:0]  o_EX_WRA;
  logic [31:0] o_EX_aluOut, o_EX_rd2;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rstn(rstn),
    .i_EX_valid(i_EX_valid), .i_EX_regWe(i_EX_regWe), .i_EX_dMemWe(i_EX_dMemWe),
    .i_EX_sByte(i_EX_sByte), .i_EX_sWRD(i_EX_sWRD), .i_EX_WRA(i_EX_WRA),
    .i_EX_rd1(i_EX_rd1), .i_EX_rd2(i_EX_rd2), .i_EX_imm(i_EX_imm),
    .i_EX_sImm(i_EX_sImm), .i_EX_aluOp(i_EX_aluOp),
    .o_EX_stall(o_EX_stall), .o_EX_regWe(o_EX_regWe), .o_EX_dMemWe(o_EX_dMemWe),
    .o_EX_sByte(o_EX_sByte), .o_EX_sWRD(o_EX_sWRD), .o_EX_WRA(o_EX_WRA),
    .o_EX_aluOut(o_EX_aluOut), .o_EX_rd2(o_EX_rd2)
  );

  typedef struct {
    logic        valid, reg_we, dmem_we, s_byte, s_wrd;
    logic [4:0]  wra;
    logic [31:0] rd1, rd2, imm;
    logic        simm;
    logic [3:0]  op;
  } instr_t;

  int vectors     = 0;
  int miscompares = 0;

  logic [72:0] obs;
  assign obs = {o_EX_regWe, o_EX_dMemWe, o_EX_sByte, o_EX_sWRD, o_EX_WRA, o_EX_aluOut, o_EX_rd2};

  // Reference result computed directly from the operation definitions.
  function automatic logic [31:0] ref_result(instr_t t);
    logic [31:0] a, b, r;
    logic [63:0] wide;
    int sh;
    a  = t.rd1;
    b  = t.simm ? t.imm : t.rd2;
    sh = int'(b % 32);
    case (t.op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: begin wide = {{32{a[31]}}, a} >> sh; r = wide[31:0]; end
      4'd11: r = b * 32'd65536;
`ifdef EX_MUL_EN
      4'd12: begin wide = 64'(a) * 64'(b); r = wide[31:0]; end
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [72:0] exp_bus(instr_t t);
    return {t.valid & t.reg_we, t.valid & t.dmem_we, t.s_byte, t.s_wrd, t.wra,
            ref_result(t), t.rd2};
  endfunction

  // Bubbles only constrain the two write enables.
  function automatic logic [72:0] bus_mask(instr_t t);
    return t.valid ? {73{1'b1}} : {2'b11, 71'd0};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    instr_t t;
    t.valid = 1'b1; t.reg_we = 1'b1; t.dmem_we = 1'b0; t.s_byte = 1'b0; t.s_wrd = 1'b1;
    t.wra = 5'd3; t.rd1 = a; t.rd2 = b; t.imm = 32'h0; t.simm = 1'b0; t.op = op;
    return t;
  endfunction

  function automatic instr_t rand_instr(bit allow_mul);
    instr_t t;
    t.valid = ($urandom_range(0, 7) != 0);
    t.reg_we = 1'($urandom); t.dmem_we = 1'($urandom);
    t.s_byte = 1'($urandom); t.s_wrd = 1'($urandom);
    t.wra = 5'($urandom); t.rd1 = pick_operand(); t.rd2 = pick_operand();
    t.imm = pick_operand(); t.simm = 1'($urandom);
    t.op = 4'($urandom_range(0, 15));
    if (!allow_mul && t.op == 4'd12) t.op = 4'd13;
    return t;
  endfunction

  task automatic drive(instr_t t);
    i_EX_valid = t.valid; i_EX_regWe = t.reg_we; i_EX_dMemWe = t.dmem_we;
    i_EX_sByte = t.s_byte; i_EX_sWRD = t.s_wrd; i_EX_WRA = t.wra;
    i_EX_rd1 = t.rd1; i_EX_rd2 = t.rd2; i_EX_imm = t.imm; i_EX_sImm = t.simm;
    i_EX_aluOp = t.op;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(rand_instr(1'b1));
    @(posedge clk); @(negedge clk);
    vectors++;
    if (obs !== 73'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    vectors++;
    if (o_EX_stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 0", o_EX_stall);
    end
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    instr_t      tv[$];
    logic [31:0] ev[$];
    instr_t      t;
    t = mk(4'd0, 32'hFFFF_FFFF, 32'd1);      tv.push_back(t); ev.push_back(32'h0000_0000);
    t = mk(4'd6, 32'h8000_0000, 32'd1);      tv.push_back(t); ev.push_back(32'h0000_0001);
    t = mk(4'd7, 32'h8000_0000, 32'd1);      tv.push_back(t); ev.push_back(32'h0000_0000);
    t = mk(4'd10, 32'h8000_0000, 32'd4);     tv.push_back(t); ev.push_back(32'hF800_0000);
    t = mk(4'd11, 32'h0, 32'h0000_ABCD);     tv.push_back(t); ev.push_back(32'hABCD_0000);
    t = mk(4'd1, 32'd0, 32'd1);              tv.push_back(t); ev.push_back(32'hFFFF_FFFF);
    t = mk(4'd15, 32'h1234, 32'h5678);       tv.push_back(t); ev.push_back(32'h0000_0000);
    t = mk(4'd0, 32'd5, 32'hDEAD);
    t.simm = 1'b1; t.imm = 32'd10;           tv.push_back(t); ev.push_back(32'd15);
`ifndef EX_MUL_EN
    t = mk(4'd12, 32'd7, 32'd6);             tv.push_back(t); ev.push_back(32'h0000_0000);
`endif
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(posedge clk); @(negedge clk);
      vectors++;
      if (o_EX_aluOut !== ev[i]) begin
        miscompares++;
        $display("FAIL directed_alu[%0d] op=%0d: got %h expected %h", i, tv[i].op, o_EX_aluOut, ev[i]);
      end
      vectors++;
      if (obs !== exp_bus(tv[i]) || o_EX_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_bus[%0d]: got %h/%b expected %h/0", i, obs, o_EX_stall, exp_bus(tv[i]));
      end
    end
    // Bubble with both enables requested must reach MEM with neither set.
    t = mk(4'd0, 32'd1, 32'd2);
    t.valid = 1'b0; t.dmem_we = 1'b1;
    drive(t);
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({o_EX_regWe, o_EX_dMemWe} !== 2'b00) begin
      miscompares++;
      $display("FAIL bubble_we: got %b%b expected 00", o_EX_regWe, o_EX_dMemWe);
    end
  endtask

  task automatic test_random();
    instr_t t;
    for (int i = 0; i < 300; i++) begin
      t = rand_instr(1'b0);
      drive(t);
      @(posedge clk); @(negedge clk);
      vectors++;
      if ((obs & bus_mask(t)) !== (exp_bus(t) & bus_mask(t)) || o_EX_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d: got %h/%b expected %h/0", i, t.op,
                 obs & bus_mask(t), o_EX_stall, exp_bus(t) & bus_mask(t));
      end
    end
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    instr_t seq[$];
    instr_t t;
    int     cnt;
    t = mk(4'd12, 32'd7, 32'd6); seq.push_back(t);
    t = mk(4'd0, 32'd100, 32'd23); seq.push_back(t);
    drive(seq[0]);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < seq.size(); i++) begin
      if (i + 1 < seq.size()) drive(seq[i+1]);
      else begin t = seq[i]; t.valid = 1'b0; drive(t); end
      cnt = 0;
      while (o_EX_stall === 1'b1 && cnt < 100) begin
        vectors++;
        if ({o_EX_regWe, o_EX_dMemWe} !== 2'b00) begin
          miscompares++;
          $display("FAIL mul_stall_we[%0d] cyc %0d: got %b%b expected 00", i, cnt, o_EX_regWe, o_EX_dMemWe);
        end
        cnt++;
        @(negedge clk);
      end
      vectors++;
      if (cnt !== ((seq[i].op == 4'd12) ? 33 : 0)) begin
        miscompares++; $display("FAIL mul_stall_len[%0d]: got %0d expected %0d", i, cnt,
                                (seq[i].op == 4'd12) ? 33 : 0);
      end
      vectors++;
      if (obs !== exp_bus(seq[i])) begin
        miscompares++; $display("FAIL mul_result[%0d]: got %h expected %h", i, obs, exp_bus(seq[i]));
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    instr_t seq[$];
    instr_t t;
    int     cnt;
    t = mk(4'd12, 32'h0001_0000, 32'h0001_0000); seq.push_back(t);
    t = mk(4'd0, 32'd1, 32'd2);                   seq.push_back(t);
    t = mk(4'd12, $urandom, $urandom);            seq.push_back(t);
    t = mk(4'd12, $urandom, 32'h0);
    t.simm = 1'b1; t.imm = $urandom; t.dmem_we = 1'b1; seq.push_back(t);
    t = rand_instr(1'b0); t.valid = 1'b1;         seq.push_back(t);
    drive(seq[0]);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < seq.size(); i++) begin
      if (i + 1 < seq.size()) drive(seq[i+1]);
      else begin t = seq[i]; t.valid = 1'b0; drive(t); end
      cnt = 0;
      while (o_EX_stall === 1'b1 && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      vectors++;
      if (cnt !== ((seq[i].op == 4'd12) ? 33 : 0)) begin
        miscompares++; $display("FAIL b2b_stall_len[%0d]: got %0d expected %0d", i, cnt,
                                (seq[i].op == 4'd12) ? 33 : 0);
      end
      vectors++;
      if (obs !== exp_bus(seq[i])) begin
        miscompares++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs, exp_bus(seq[i]));
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_busy();
    instr_t t;
    t = mk(4'd12, 32'd123, 32'd456);
    drive(t);
    @(posedge clk); @(negedge clk);
    // First stall cycle is the start cycle; eleven more reach step 10.
    for (int i = 0; i < 11; i++) @(negedge clk);
    vectors++;
    if (o_EX_stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_busy_pre: got %b expected 1", o_EX_stall);
    end
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (obs !== 73'd0 || o_EX_stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_busy_out: got %h/%b expected 0/0", obs, o_EX_stall);
    end
    rstn = 1'b1;
    t = mk(4'd4, 32'hF0F0_0000, 32'h0F0F_1234);
    drive(t);
    @(posedge clk); @(negedge clk);
    vectors++;
    if (obs !== exp_bus(t) || o_EX_stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_busy_after: got %h/%b expected %h/0", obs, o_EX_stall, exp_bus(t));
    end
  endtask
`endif

  initial begin
    rstn = 1'b1;
    drive(mk(4'd0, 32'd0, 32'd0));
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
`ifdef EX_MUL_EN
    test_mul();
    test_back_to_back();
    test_reset_busy();
`endif
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset: clk, rstn.
REQ-002 SHALL provide ports: clk  in  1  rising-edge clock.
REQ-003 SHALL provide: rstn  in  1  synchronous active-low reset.
REQ-004 SHALL provide: i_EX_valid  in  1  ID-stage instruction valid; 0 = bubble.
REQ-005 SHALL provide: i_EX_regWe, i_EX_dMemWe, i_EX_sByte, i_EX_sWRD  in  1 each  control bits forwarded to MEM.
REQ-006 SHALL provide: i_EX_WRA  in  5  register-file write address.
REQ-007 SHALL provide: i_EX_rd1, i_EX_rd2, i_EX_imm  in  32 each  operand A, operand B/store data, extended immediate.
REQ-008 SHALL provide: i_EX_sImm  in  1  1 = operand B is imm.
REQ-009 SHALL provide: i_EX_aluOp  in  4  operation code.
REQ-010 SHALL provide: o_EX_stall  out  1  hold ID/IF; do not advance.
REQ-011 SHALL provide: o_EX_regWe, o_EX_dMemWe, o_EX_sByte, o_EX_sWRD  out  1 each; o_EX_WRA  out  5; o_EX_aluOut, o_EX_rd2  out  32 -- MEM-stage inputs.

Function
REQ-012 EX register SHALL capture all inputs on clk when o_EX_stall=0 and hold them when o_EX_stall=1.
REQ-013 i_EX_valid=0 at capture SHALL load regWe=dMemWe=0 (bubble); other fields don't-care.
REQ-014 Outputs SHALL be combinational from the EX register plus ALU; MEM provides the next register, so single-cycle ops add one cycle of latency.
REQ-015 ALU ops: 0 ADD, 1 SUB (mod 2^32, no trap), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift amount B[4:0]), 11 LUI (B<<16), 12 MUL (low 32 bits of A*B), 13-15 result 0.
REQ-016 o_EX_rd2 SHALL equal registered rd2 regardless of sImm.
REQ-017 MUL FSM states IDLE, BUSY, DONE: IDLE with valid MUL registered -> BUSY, count=0; BUSY performs one shift-add step per cycle, count==31 -> DONE; DONE -> IDLE.
REQ-018 o_EX_stall SHALL be 1 in IDLE with valid MUL registered and in BUSY; 0 otherwise (33 stall cycles per MUL).
REQ-019 While o_EX_stall=1, o_EX_regWe and o_EX_dMemWe SHALL be 0 (bubbles to MEM).
REQ-020 In DONE, o_EX_aluOut SHALL be the product and control bits pass unmasked for exactly one cycle.
REQ-021 Back-to-back MULs SHALL each run full sequence; DONE of the first captures the second.

Reset
REQ-022 rstn=0 at clk edge SHALL clear EX register, counter, product to 0, FSM to IDLE; all outputs 0 next cycle, o_EX_stall=0.
REQ-023 Reset during BUSY SHALL abort the multiply, discarding the partial product.

Configuration
REQ-024 Macro EX_MUL_EN defined: MUL op and FSM as specified.
REQ-025 EX_MUL_EN undefined: no FSM or multiplier instantiated, o_EX_stall tied 0, op 12 yields 0 in one cycle.

Structure
REQ-026 Package ex_pkg SHALL hold aluOp encodings, FSM state enum, MUL_STEPS=32.
REQ-027 Iterative multiplier SHALL be sub-module mul_iter (start, busy, done, 32-bit operands, 32-bit product).

Verification
REQ-028 ADD rd1=0xFFFFFFFF, rd2=1 -> aluOut 0x00000000 next cycle, stall 0.
REQ-029 SLT rd1=0x80000000, rd2=1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-030 MUL 7*6, regWe=1 -> stall high 33 cycles, regWe out 0 throughout, then aluOut 42 with regWe 1 for one cycle.
REQ-031 MUL 0x10000*0x10000 -> aluOut 0 (low word); next ADD captured in the DONE cycle completes one cycle later.
REQ-032 rstn=0 at BUSY count 10 -> next cycle stall 0, all outputs 0, FSM IDLE.
REQ-033 i_EX_valid=0 with regWe=1, dMemWe=1 -> o_EX_regWe=o_EX_dMemWe=0.
